// File: rtl/crc_frame_ctrl.sv
// crc_frame_ctrl
//   Arbitrates two byte-oriented requesters onto a bit-serial 8-bit CRC
//   engine (seed 0xD8, taps 0x44). For every frame it re-seeds the engine
//   and streams the bytes LSB-first with ACTIVE held without a break. It then
//   gathers the 8 serial CRC bits into CRC_OUT and reports DONE and DONE_ID.
//
// Ports
//   CLK, RST          clock, asynchronous active-low reset
//   REQ[1:0]          per-requester frame request, held for the whole frame
//   LEN               {LEN1, LEN0}, byte count minus 1, sampled at grant
//   DIN               {DIN1, DIN0}, current byte of each requester
//   GNT[1:0]          one-hot grant, held until DONE or the end of the flush
//   ACK[1:0]          the current DIN byte was consumed
//   CRC_RST_N         engine reset, registered
//   CRC_ACTIVE/DATA   serial data into the engine
//   CRC_BIT/VALID     serial CRC out of the engine
//   CRC_OUT           assembled CRC; the first bit received is bit 0
//   DONE, ABORT       one-cycle completion / abandon pulses
//   DONE_ID           requester of the last grant
module crc_frame_ctrl #(
  parameter int LEN_W = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [1:0]         REQ,
  input  logic [2*LEN_W-1:0] LEN,
  input  logic [15:0]        DIN,
  output logic [1:0]         GNT,
  output logic [1:0]         ACK,
  output logic               CRC_RST_N,
  output logic               CRC_ACTIVE,
  output logic               CRC_DATA,
  input  logic               CRC_BIT,
  input  logic               CRC_VALID,
  output logic [7:0]         CRC_OUT,
  output logic               DONE,
  output logic               DONE_ID,
  output logic               ABORT
);

  typedef enum logic [2:0] {S_IDLE, S_SEED, S_SHIFT, S_COLLECT, S_FLUSH} state_t;

  state_t             state_q, state_d;
  logic               ptr_q, ptr_d;
  logic               gid_q, gid_d;
  logic [1:0]         gnt_q, gnt_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   byte_q, byte_d;
  logic [2:0]         bit_q, bit_d;
  logic [7:0]         sh_q, sh_d;
  logic [7:0]         col_q, col_d;
  logic [7:0]         crc_q, crc_d;
  logic               done_q, done_d;
  logic               abort_q, abort_d;
  logic               rstn_q, rstn_d;
  logic               skip_q, skip_d;

  logic               gsel;
  logic               req_g;
  logic               last_byte;
  logic [7:0]         cur_din;
  logic [7:0]         col_nx;
  logic               ack_c;

  assign req_g     = REQ[gid_q];
  assign cur_din   = gid_q ? DIN[15:8] : DIN[7:0];
  assign last_byte = (byte_q == len_q);
  assign col_nx    = {CRC_BIT, col_q[7:1]};
  // Pointer's requester first, the other one if the pointer's is idle.
  assign gsel      = REQ[ptr_q] ? ptr_q : ~ptr_q;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gid_d   = gid_q;
    gnt_d   = gnt_q;
    len_d   = len_q;
    byte_d  = byte_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    col_d   = col_q;
    crc_d   = crc_q;
    done_d  = 1'b0;
    abort_d = 1'b0;
    rstn_d  = 1'b1;
    skip_d  = skip_q;
    case (state_q)
      S_IDLE: begin
        if (|REQ) begin
          gid_d   = gsel;
          gnt_d   = gsel ? 2'b10 : 2'b01;
          len_d   = gsel ? LEN[2*LEN_W-1:LEN_W] : LEN[LEN_W-1:0];
          rstn_d  = 1'b0;           // engine is held in reset for the SEED cycle
          state_d = S_SEED;
        end
      end
      S_SEED: begin
        bit_d = 3'd0;
        if (!req_g) begin
          // The engine never saw ACTIVE, so it will not produce a readout to drain.
          abort_d = 1'b1;
          skip_d  = 1'b1;
          state_d = S_FLUSH;
        end else begin
          sh_d    = cur_din;
          byte_d  = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (!req_g) begin
          abort_d = 1'b1;
          skip_d  = 1'b0;
          bit_d   = 3'd0;
          state_d = S_FLUSH;
        end else begin
          sh_d  = {1'b0, sh_q[7:1]};
          bit_d = bit_q + 3'd1;       // wraps to 0 at a byte boundary
          if (bit_q == 3'd7) begin
            if (last_byte) begin
              state_d = S_COLLECT;
            end else begin
              // Reload on the same cycle as bit 7 so ACTIVE never gaps.
              sh_d   = cur_din;
              byte_d = byte_q + LEN_W'(1);
            end
          end
        end
      end
      S_COLLECT: begin
        if (CRC_VALID) begin
          col_d = col_nx;
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            crc_d   = col_nx;
            done_d  = 1'b1;
            gnt_d   = 2'b00;
            ptr_d   = ~gid_q;
            state_d = S_IDLE;
          end
        end
      end
      S_FLUSH: begin
        if (skip_q || (CRC_VALID && bit_q == 3'd7)) begin
          gnt_d   = 2'b00;
          ptr_d   = ~gid_q;
          skip_d  = 1'b0;
          state_d = S_IDLE;
        end else if (CRC_VALID) begin
          bit_d = bit_q + 3'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
      ptr_q   <= 1'b0;
      gid_q   <= 1'b0;
      gnt_q   <= 2'b00;
      len_q   <= '0;
      byte_q  <= '0;
      bit_q   <= 3'd0;
      sh_q    <= 8'h00;
      col_q   <= 8'h00;
      crc_q   <= 8'h00;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
      rstn_q  <= 1'b1;
      skip_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
      gnt_q   <= gnt_d;
      len_q   <= len_d;
      byte_q  <= byte_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      col_q   <= col_d;
      crc_q   <= crc_d;
      done_q  <= done_d;
      abort_q <= abort_d;
      rstn_q  <= rstn_d;
      skip_q  <= skip_d;
    end
  end

  // ACK is withheld once the requester has dropped REQ.
  assign ack_c = req_g && ((state_q == S_SEED) ||
                           (state_q == S_SHIFT && bit_q == 3'd7 && !last_byte));

  assign GNT        = gnt_q;
  assign ACK        = gnt_q & {2{ack_c}};
  assign CRC_RST_N  = rstn_q;
  assign CRC_ACTIVE = (state_q == S_SHIFT);
  assign CRC_DATA   = (state_q == S_SHIFT) & sh_q[0];
  assign CRC_OUT    = crc_q;
  assign DONE       = done_q;
  assign DONE_ID    = gid_q;
  assign ABORT      = abort_q;

endmodule
